// File: rtl/eu_speriph_plug_arbiter_pkg.sv
// Shared types and constants for the event-unit peripheral plug arbiter.
// Holds the FSM state type, the watchdog error data word and a wrap helper.
package eu_speriph_plug_arbiter_pkg;

    localparam int NB_SPERIPH_PLUGS_EU = 2;

    localparam logic [31:0] EU_ARB_ERR_RDATA = 32'hBADACCE5;

    typedef enum logic {
        EU_ARB_IDLE,
        EU_ARB_WAIT_RESP
    } eu_arb_state_e;

    function automatic int unsigned eu_arb_wrap_inc(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/eu_speriph_plug_arbiter_if.sv
// Bundle of plug-side (s_*) and event-unit-side (m_*) bus signals.
// slave: arbiter view; master: view of the plugs plus the event unit.
interface eu_speriph_plug_arbiter_if #(
    parameter int NB_PLUGS   = 2,
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NB_PLUGS-1:0]                 s_req_i;
    logic [NB_PLUGS-1:0][ADDR_WIDTH-1:0] s_add_i;
    logic [NB_PLUGS-1:0]                 s_wen_i;
    logic [NB_PLUGS-1:0][DATA_WIDTH-1:0] s_wdata_i;
    logic [NB_PLUGS-1:0][BE_WIDTH-1:0]   s_be_i;
    logic [NB_PLUGS-1:0][ID_WIDTH-1:0]   s_id_i;
    logic [NB_PLUGS-1:0]                 s_gnt_o;
    logic [NB_PLUGS-1:0]                 s_r_valid_o;
    logic [NB_PLUGS-1:0]                 s_r_opc_o;
    logic [NB_PLUGS-1:0][ID_WIDTH-1:0]   s_r_id_o;
    logic [NB_PLUGS-1:0][DATA_WIDTH-1:0] s_r_rdata_o;

    logic                  m_req_o;
    logic [ADDR_WIDTH-1:0] m_add_o;
    logic                  m_wen_o;
    logic [DATA_WIDTH-1:0] m_wdata_o;
    logic [BE_WIDTH-1:0]   m_be_o;
    logic [ID_WIDTH-1:0]   m_id_o;
    logic                  m_gnt_i;
    logic                  m_r_valid_i;
    logic                  m_r_opc_i;
    logic [ID_WIDTH-1:0]   m_r_id_i;
    logic [DATA_WIDTH-1:0] m_r_rdata_i;

    modport slave (
        input  s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i, s_id_i,
        output s_gnt_o, s_r_valid_o, s_r_opc_o, s_r_id_o, s_r_rdata_o,
        output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o, m_id_o,
        input  m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_id_i, m_r_rdata_i
    );

    modport master (
        output s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i, s_id_i,
        input  s_gnt_o, s_r_valid_o, s_r_opc_o, s_r_id_o, s_r_rdata_o,
        input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o, m_id_o,
        output m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_id_i, m_r_rdata_i
    );

endinterface

// File: rtl/eu_speriph_plug_arbiter_rr_sel.sv
// Round-robin priority select: first set request at or after i_ptr (wrapping).
// Ports: i_req request vector, i_ptr start index, o_idx winner, o_valid any request.
module eu_rr_prio_sel #(
    parameter int NB_PLUGS = 2
) (
    input  logic [NB_PLUGS-1:0]         i_req,
    input  logic [$clog2(NB_PLUGS)-1:0] i_ptr,
    output logic [$clog2(NB_PLUGS)-1:0] o_idx,
    output logic                        o_valid
);
    localparam int PW = $clog2(NB_PLUGS);

    always_comb begin : p_sel
        int          k;
        logic [PW-1:0] w_k;
        o_idx   = '0;
        o_valid = 1'b0;
        k       = 0;
        w_k     = '0;
        for (int i = 0; i < NB_PLUGS; i++) begin
            k = int'(i_ptr) + i;
            if (k >= NB_PLUGS) k = k - NB_PLUGS;
            w_k = PW'(k);
            if (!o_valid && i_req[w_k]) begin
                o_valid = 1'b1;
                o_idx   = w_k;
            end
        end
    end

endmodule

// File: rtl/eu_speriph_plug_arbiter.sv
// Round-robin arbiter sharing the event-unit slave port between NB_PLUGS plugs,
// with response steering and a response watchdog.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport), err_o (timeout pulse).
module eu_speriph_plug_arbiter
    import eu_speriph_plug_arbiter_pkg::*;
#(
    parameter int NB_PLUGS   = NB_SPERIPH_PLUGS_EU,
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    eu_speriph_plug_arbiter_if.slave    bus,
    output logic                        err_o
);
    localparam int PW = $clog2(NB_PLUGS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    eu_arb_state_e       r_state;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_lock_idx;
    logic [PW-1:0]       r_owner;
    logic                r_lock;
    logic [ID_WIDTH-1:0] r_id_q;

    logic [PW-1:0] w_sel_idx;
    logic [PW-1:0] w_winner;
    logic          w_sel_valid;
    logic          w_lock_hit;
    logic          w_req_phase;
    logic          w_m_req;
    logic          w_hs;
    logic          w_timeout;

    eu_rr_prio_sel #(.NB_PLUGS(NB_PLUGS)) u_sel (
        .i_req   (bus.s_req_i),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    // A stalled plug keeps the bus until granted; if it drops its
    // request the lock is ignored and normal round-robin resumes.
    assign w_lock_hit  = r_lock & bus.s_req_i[r_lock_idx];
    assign w_winner    = w_lock_hit ? r_lock_idx : w_sel_idx;
    assign w_req_phase = (r_state == EU_ARB_IDLE) |
                         ((r_state == EU_ARB_WAIT_RESP) & bus.m_r_valid_i);
    assign w_m_req     = w_req_phase & w_sel_valid;
    assign w_hs        = w_m_req & bus.m_gnt_i;

    always_comb begin
        bus.m_req_o   = w_m_req;
        bus.m_add_o   = '0;
        bus.m_wen_o   = 1'b0;
        bus.m_wdata_o = '0;
        bus.m_be_o    = '0;
        bus.m_id_o    = '0;
        bus.s_gnt_o   = '0;
        if (w_m_req) begin
            bus.m_add_o           = bus.s_add_i[w_winner];
            bus.m_wen_o           = bus.s_wen_i[w_winner];
            bus.m_wdata_o         = bus.s_wdata_i[w_winner];
            bus.m_be_o            = bus.s_be_i[w_winner];
            bus.m_id_o            = bus.s_id_i[w_winner];
            bus.s_gnt_o[w_winner] = bus.m_gnt_i;
        end
    end

    always_comb begin
        bus.s_r_valid_o = '0;
        bus.s_r_opc_o   = '0;
        bus.s_r_id_o    = '0;
        bus.s_r_rdata_o = '0;
        if (r_state == EU_ARB_WAIT_RESP) begin
            if (w_timeout) begin
                bus.s_r_valid_o[r_owner] = 1'b1;
                bus.s_r_opc_o[r_owner]   = 1'b1;
                bus.s_r_id_o[r_owner]    = r_id_q;
                bus.s_r_rdata_o[r_owner] = DATA_WIDTH'(EU_ARB_ERR_RDATA);
            end else begin
                bus.s_r_valid_o[r_owner] = bus.m_r_valid_i;
                bus.s_r_opc_o[r_owner]   = bus.m_r_opc_i;
                bus.s_r_id_o[r_owner]    = bus.m_r_id_i;
                bus.s_r_rdata_o[r_owner] = bus.m_r_rdata_i;
            end
        end
    end

    assign err_o = w_timeout;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                end else if (w_hs) begin
                    r_cnt <= '0;
                end else if (r_state == EU_ARB_WAIT_RESP && !bus.m_r_valid_i) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign w_timeout = (r_state == EU_ARB_WAIT_RESP) & ~bus.m_r_valid_i &
                               (r_cnt == CW'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= EU_ARB_IDLE;
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_owner    <= '0;
            r_id_q     <= '0;
        end else begin
            if (w_hs) begin
                r_state  <= EU_ARB_WAIT_RESP;
                r_owner  <= w_winner;
                r_id_q   <= bus.s_id_i[w_winner];
                r_rr_ptr <= PW'(eu_arb_wrap_inc(32'(w_winner), NB_PLUGS));
            end else if (r_state == EU_ARB_WAIT_RESP &&
                         (bus.m_r_valid_i || w_timeout)) begin
                r_state <= EU_ARB_IDLE;
            end

            if (w_hs) begin
                r_lock <= 1'b0;
            end else if (w_m_req) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_winner;
            end else if (r_lock && !bus.s_req_i[r_lock_idx]) begin
                r_lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eu_speriph_plug_arbiter.sv
// Scoreboard bench for eu_speriph_plug_arbiter: directed scenarios plus
// random traffic against a transaction-level round-robin reference model.
module tb_eu_speriph_plug_arbiter;
    import eu_speriph_plug_arbiter_pkg::*;

    localparam int N   = 2;
    localparam int IDW = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int NRND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    always #5 clk = ~clk;

    eu_speriph_plug_arbiter_if #(
        .NB_PLUGS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) bus ();

    eu_speriph_plug_arbiter #(
        .NB_PLUGS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .err_o  (err)
    );

    typedef struct {
        int            plug;
        logic [IDW-1:0] id;
        logic [AW-1:0]  add;
        logic           wen;
        logic [DW-1:0]  wd;
    } gnt_t;

    typedef struct {
        int            plug;
        logic [IDW-1:0] id;
        logic [DW-1:0]  rd;
        logic           opc;
        logic           er;
    } rsp_t;

    gnt_t q_g[$];
    rsp_t q_r[$];
    gnt_t mg;
    rsp_t mr;

    int n_chk = 0;
    int n_err = 0;
    int gnt_seen = 0;

    logic [N-1:0][IDW-1:0] e_id;
    logic [N-1:0][DW-1:0]  e_rd;
    logic [N-1:0]          e_opc;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input logic [127:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %0h expected nothing", nm, act);
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        return N'(1) << p;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a grant or response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|bus.s_gnt_o) begin
                gnt_seen++;
                if (q_g.size() == 0) begin
                    bad("gnt_unexpected", bus.s_gnt_o);
                end else begin
                    mg = q_g.pop_front();
                    chk("gnt_vec", bus.s_gnt_o, onehot(mg.plug));
                    chk("gnt_id", bus.m_id_o, mg.id);
                    chk("gnt_add", bus.m_add_o, mg.add);
                    chk("gnt_wen", bus.m_wen_o, mg.wen);
                    chk("gnt_wdata", bus.m_wdata_o, mg.wd);
                end
            end
            if (|bus.s_r_valid_o) begin
                if (q_r.size() == 0) begin
                    bad("rsp_unexpected", bus.s_r_valid_o);
                end else begin
                    mr = q_r.pop_front();
                    e_id = '0;
                    e_rd = '0;
                    e_opc = '0;
                    e_id[mr.plug] = mr.id;
                    e_rd[mr.plug] = mr.rd;
                    e_opc[mr.plug] = mr.opc;
                    chk("rsp_vec", bus.s_r_valid_o, onehot(mr.plug));
                    chk("rsp_id", bus.s_r_id_o, e_id);
                    chk("rsp_rdata", bus.s_r_rdata_o, e_rd);
                    chk("rsp_opc", bus.s_r_opc_o, e_opc);
                    chk("rsp_err", err, mr.er);
                end
            end else if (err) begin
                bad("err_without_rsp", err);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.s_req_i = '0;
        bus.s_add_i = '0;
        bus.s_wen_i = '0;
        bus.s_wdata_i = '0;
        bus.s_be_i = '0;
        bus.s_id_i = '0;
        bus.m_gnt_i = 1'b0;
        bus.m_r_valid_i = 1'b0;
        bus.m_r_opc_i = 1'b0;
        bus.m_r_id_i = '0;
        bus.m_r_rdata_i = '0;
    endtask

    task automatic set_plug(input int p, input logic rq, input logic [IDW-1:0] id,
                            input logic [AW-1:0] add, input logic wen,
                            input logic [DW-1:0] wd);
        bus.s_req_i[p] = rq;
        bus.s_id_i[p] = id;
        bus.s_add_i[p] = add;
        bus.s_wen_i[p] = wen;
        bus.s_wdata_i[p] = wd;
        bus.s_be_i[p] = '1;
    endtask

    task automatic resp(input logic [IDW-1:0] id, input logic [DW-1:0] rd,
                        input logic opc);
        bus.m_r_valid_i = 1'b1;
        bus.m_r_id_i = id;
        bus.m_r_rdata_i = rd;
        bus.m_r_opc_i = opc;
    endtask

    task automatic expg(input int p, input logic [IDW-1:0] id,
                        input logic [AW-1:0] add, input logic wen,
                        input logic [DW-1:0] wd);
        q_g.push_back('{p, id, add, wen, wd});
    endtask

    task automatic expr(input int p, input logic [IDW-1:0] id,
                        input logic [DW-1:0] rd, input logic opc, input logic er);
        q_r.push_back('{p, id, rd, opc, er});
    endtask

    task automatic do_reset();
        chk("queues_drained", q_g.size() + q_r.size(), 0);
        rst_n = 1'b0;
        idle_in();
        next();
        next();
        rst_n = 1'b1;
    endtask

    // Random-traffic reference model state
    logic [N-1:0]   pend;
    logic [IDW-1:0] tid [N];
    logic [AW-1:0]  tadd [N];
    logic           twen [N];
    logic [DW-1:0]  twd [N];
    int             wait_g [N];
    int             max_wait;
    int             mptr, pres, owner, dly, w, g0, pid;
    logic           busy, rv, gn, hs, ropc;
    logic [IDW-1:0] out_id;
    logic [DW-1:0]  rrd;

    initial begin
        idle_in();
        #2;
        chk("rst_gnt", bus.s_gnt_o, 0);
        chk("rst_rvalid", bus.s_r_valid_o, 0);
        chk("rst_mreq", bus.m_req_o, 0);
        chk("rst_err", err, 0);
        do_reset();

        // 1: single read from plug0
        set_plug(0, 1'b1, 5'd3, 32'h0000_0040, 1'b1, '0);
        bus.m_gnt_i = 1'b1;
        expg(0, 5'd3, 32'h0000_0040, 1'b1, '0);
        next();
        idle_in();
        resp(5'd3, 32'h1234, 1'b0);
        expr(0, 5'd3, 32'h1234, 1'b0, 1'b0);
        next();
        idle_in();
        set_plug(1, 1'b1, 5'd6, 32'h0000_0044, 1'b1, '0);
        @(negedge clk);
        chk("t1_back_idle", bus.m_req_o, 1);
        next();
        idle_in();

        // 2: both plugs request back-to-back, responses one cycle later
        do_reset();
        g0 = gnt_seen;
        pid = 0;
        for (int c = 0; c < 6; c++) begin
            int t0, t1;
            t0 = (c + 1) / 2;
            t1 = c / 2;
            set_plug(0, 1'b1, IDW'(2 * t0 + 1), AW'(32'h100 + t0), 1'b1, '0);
            set_plug(1, 1'b1, IDW'(2 * t1 + 2), AW'(32'h200 + t1), 1'b0,
                     DW'(32'hA0 + t1));
            bus.m_gnt_i = 1'b1;
            bus.m_r_valid_i = 1'b0;
            w = c % 2;
            if (c > 0) begin
                resp(IDW'(pid), DW'(32'h5000 + c), 1'b0);
                expr(1 - w, IDW'(pid), DW'(32'h5000 + c), 1'b0, 1'b0);
            end
            if (w == 0) begin
                expg(0, IDW'(2 * t0 + 1), AW'(32'h100 + t0), 1'b1, '0);
                pid = 2 * t0 + 1;
            end else begin
                expg(1, IDW'(2 * t1 + 2), AW'(32'h200 + t1), 1'b0, DW'(32'hA0 + t1));
                pid = 2 * t1 + 2;
            end
            next();
        end
        idle_in();
        resp(IDW'(pid), 32'h6000, 1'b0);
        expr(1, IDW'(pid), 32'h6000, 1'b0, 1'b0);
        next();
        idle_in();
        chk("t2_no_bubble", gnt_seen - g0, 6);

        // 3: stalled plug1 keeps the bus while plug0 joins
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            set_plug(1, 1'b1, 5'd9, 32'hC0DE_0001, 1'b1, '0);
            if (c >= 2) set_plug(0, 1'b1, 5'd8, 32'hC0DE_0000, 1'b0, 32'h77);
            bus.m_gnt_i = 1'b0;
            @(negedge clk);
            chk("t3_hold_add", bus.m_add_o, 32'hC0DE_0001);
            next();
        end
        bus.m_gnt_i = 1'b1;
        expg(1, 5'd9, 32'hC0DE_0001, 1'b1, '0);
        next();
        set_plug(1, 1'b0, '0, '0, 1'b0, '0);
        resp(5'd9, 32'h1111, 1'b0);
        expr(1, 5'd9, 32'h1111, 1'b0, 1'b0);
        expg(0, 5'd8, 32'hC0DE_0000, 1'b0, 32'h77);
        next();
        idle_in();
        resp(5'd8, 32'h2222, 1'b1);
        expr(0, 5'd8, 32'h2222, 1'b1, 1'b0);
        next();
        idle_in();

        // 4: watchdog fires on the 16th waiting cycle; late response dropped
        do_reset();
        set_plug(0, 1'b1, 5'd7, 32'h0000_0080, 1'b1, '0);
        bus.m_gnt_i = 1'b1;
        expg(0, 5'd7, 32'h0000_0080, 1'b1, '0);
        expr(0, 5'd7, EU_ARB_ERR_RDATA, 1'b1, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            next();
            idle_in();
            @(negedge clk);
            chk("t4_err_timing", err, (k == 16) ? 1 : 0);
        end
        next();
        resp(5'd7, 32'h4321, 1'b0);
        @(negedge clk);
        chk("t4_late_drop", {bus.s_r_valid_o, err}, 0);
        next();
        idle_in();

        // 5: async reset while waiting for a response
        do_reset();
        set_plug(0, 1'b1, 5'd4, 32'h0000_00C0, 1'b1, '0);
        bus.m_gnt_i = 1'b1;
        expg(0, 5'd4, 32'h0000_00C0, 1'b1, '0);
        next();
        idle_in();
        #1;
        rst_n = 1'b0;
        resp(5'd4, 32'hDEAD_BEEF, 1'b1);
        #1;
        chk("t5_rst_rvalid", bus.s_r_valid_o, 0);
        chk("t5_rst_rdata", bus.s_r_rdata_o, 0);
        chk("t5_rst_rid", bus.s_r_id_o, 0);
        chk("t5_rst_err", err, 0);
        chk("t5_rst_mreq", {bus.m_req_o, bus.s_gnt_o}, 0);
        next();
        idle_in();
        rst_n = 1'b1;
        set_plug(0, 1'b1, 5'd12, 32'h0000_0100, 1'b1, '0);
        set_plug(1, 1'b1, 5'd13, 32'h0000_0104, 1'b1, '0);
        bus.m_gnt_i = 1'b1;
        expg(0, 5'd12, 32'h0000_0100, 1'b1, '0);
        next();
        set_plug(0, 1'b0, '0, '0, 1'b0, '0);
        resp(5'd12, 32'hAAAA, 1'b0);
        expr(0, 5'd12, 32'hAAAA, 1'b0, 1'b0);
        expg(1, 5'd13, 32'h0000_0104, 1'b1, '0);
        next();
        idle_in();
        resp(5'd13, 32'hBBBB, 1'b0);
        expr(1, 5'd13, 32'hBBBB, 1'b0, 1'b0);
        next();
        idle_in();

        // 6: random traffic against the transaction-level model
        do_reset();
        pend = '0;
        mptr = 0;
        pres = -1;
        busy = 1'b0;
        owner = 0;
        dly = 0;
        out_id = '0;
        max_wait = 0;
        for (int p = 0; p < N; p++) wait_g[p] = 0;
        for (int c = 0; c < NRND + 200; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!pend[p] && c < NRND && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    tid[p] = IDW'($urandom);
                    tadd[p] = $urandom;
                    twen[p] = 1'($urandom_range(0, 1));
                    twd[p] = $urandom;
                    wait_g[p] = 0;
                end
                set_plug(p, pend[p], tid[p], tadd[p], twen[p], twd[p]);
            end
            rv = 1'b0;
            if (busy) begin
                if (dly == 0) rv = 1'b1;
                else dly--;
            end
            rrd = $urandom;
            ropc = ($urandom_range(0, 7) == 0);
            bus.m_r_valid_i = rv;
            bus.m_r_id_i = rv ? out_id : IDW'($urandom);
            bus.m_r_rdata_i = rrd;
            bus.m_r_opc_i = ropc;
            if (rv) expr(owner, out_id, rrd, ropc, 1'b0);
            gn = ($urandom_range(0, 3) != 0);
            bus.m_gnt_i = gn;
            hs = 1'b0;
            if ((!busy || rv) && (|pend)) begin
                if (pres >= 0) begin
                    w = pres;
                end else begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
                end
                if (gn) begin
                    expg(w, tid[w], tadd[w], twen[w], twd[w]);
                    hs = 1'b1;
                    owner = w;
                    out_id = tid[w];
                    dly = $urandom_range(0, TO - 2);
                    mptr = (w + 1) % N;
                    pres = -1;
                    pend[w] = 1'b0;
                    for (int q = 0; q < N; q++) begin
                        if (q != w && pend[q]) begin
                            wait_g[q]++;
                            if (wait_g[q] > max_wait) max_wait = wait_g[q];
                        end
                    end
                end else begin
                    pres = w;
                end
            end
            if (hs) busy = 1'b1;
            else if (rv) busy = 1'b0;
            next();
        end
        idle_in();
        next();
        chk("t6_all_granted", {busy, pend}, 0);
        chk("t6_starvation", (max_wait <= N) ? 1 : 0, 1);
        chk("t6_queues_empty", q_g.size() + q_r.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
